// File: rtl/xmit_ser_pkg.sv
// xmit_ser shared types and constants.
// Optional parity build: define XMIT_SER_PARITY_EN.
package xmit_ser_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  localparam int SER_DATA_W = 8;
  localparam logic SER_IDLE_LVL = 1'b1;
endpackage

// File: rtl/xmit_ser_baud.sv
// Baud tick generator for xmit_ser.
// bit_tick marks the last cycle of each bit period.
module xmit_ser_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/xmit_ser.sv
// Byte-to-serial line transmitter with one-byte holding register.
// Optional even parity bit: define XMIT_SER_PARITY_EN.
import xmit_ser_pkg::*;

module xmit_ser #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SER_DATA_W-1:0] ser_in_data,
  input  logic                  ser_in_valid,
  output logic                  ser_in_ready,
  output logic                  ser_tx_out,
  output logic                  ser_busy,
  output logic                  ser_frame_done
);
  ser_state_t            state;
  logic [SER_DATA_W-1:0] hold_data;
  logic                  hold_full;
  logic [SER_DATA_W-1:0] shreg;
  logic [2:0]            bit_cnt;
  logic [0:0]            stop_cnt;
  logic                  bit_tick;
  logic                  last_stop;
  logic                  frame_end;
  logic                  pull;
`ifdef XMIT_SER_PARITY_EN
  logic                  par;
`endif

  xmit_ser_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .bit_tick(bit_tick)
  );

  assign ser_in_ready   = !hold_full;
  assign last_stop      = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_end      = (state == STOP) && last_stop && bit_tick;
  assign ser_frame_done = frame_end;
  // The only two points where a held byte may start a frame.
  assign pull = hold_full && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ser_tx_out <= SER_IDLE_LVL;
      ser_busy   <= 1'b0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
`ifdef XMIT_SER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      if (ser_in_valid && !hold_full) begin
        hold_data <= ser_in_data;
        hold_full <= 1'b1;
      end
      unique case (state)
        IDLE: ;
        START: if (bit_tick) begin
          state      <= DATA;
          bit_cnt    <= '0;
          ser_tx_out <= shreg[0];
          shreg      <= shreg >> 1;
        end
        DATA: if (bit_tick) begin
          if (bit_cnt == 3'(SER_DATA_W - 1)) begin
`ifdef XMIT_SER_PARITY_EN
            state      <= PARITY;
            ser_tx_out <= par;
`else
            state      <= STOP;
            stop_cnt   <= '0;
            ser_tx_out <= SER_IDLE_LVL;
`endif
          end else begin
            bit_cnt    <= bit_cnt + 3'd1;
            ser_tx_out <= shreg[0];
            shreg      <= shreg >> 1;
          end
        end
`ifdef XMIT_SER_PARITY_EN
        PARITY: if (bit_tick) begin
          state      <= STOP;
          stop_cnt   <= '0;
          ser_tx_out <= SER_IDLE_LVL;
        end
`endif
        STOP: if (bit_tick) begin
          if (last_stop) begin
            state    <= IDLE;
            ser_busy <= 1'b0;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (pull) begin
        state      <= START;
        hold_full  <= 1'b0;
        shreg      <= hold_data;
        ser_tx_out <= 1'b0;
        ser_busy   <= 1'b1;
`ifdef XMIT_SER_PARITY_EN
        par        <= ^hold_data;
`endif
      end
    end
  end
endmodule

// File: tb/tb_xmit_ser.sv
// Scoreboard bench for xmit_ser.
// Parity build expectations follow XMIT_SER_PARITY_EN.
module tb_xmit_ser;
  localparam int CPB = 4;
`ifdef XMIT_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 10 + P;
  localparam int FL = NB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic valid = 1'b0;
  logic ready, tx, busy, done;
  logic [7:0] data2 = 8'h00;
  logic valid2 = 1'b0;
  logic ready2, tx2, busy2, done2;

  always #5 clk = ~clk;

  xmit_ser #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst),
    .ser_in_data(data), .ser_in_valid(valid),
    .ser_in_ready(ready), .ser_tx_out(tx),
    .ser_busy(busy), .ser_frame_done(done)
  );

  xmit_ser #(.CLKS_PER_BIT(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst),
    .ser_in_data(data2), .ser_in_valid(valid2),
    .ser_in_ready(ready2), .ser_tx_out(tx2),
    .ser_busy(busy2), .ser_frame_done(done2)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  bit mon_en = 1'b0;
  bit mon_busy = 1'b0;
  int prev_end = -10;
  int contig = 0;
  logic [11:0] last_bits = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic fbit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (P == 1 && i == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  initial begin : mon
    logic [7:0] e;
    logic [11:0] s;
    int errs;
    logic eb;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx === 1'b0) begin
        mon_busy = 1'b1;
        if (prev_end == cyc - 1) contig++;
        errs = 0;
        s = '0;
        if (sb.size() > 0) e = sb.pop_front();
        else begin
          e = 8'h00;
          errs = 1;
        end
        for (int c = 0; c < FL; c++) begin
          if (c > 0) @(negedge clk);
          eb = fbit(e, c / CPB);
          if (tx !== eb || busy !== 1'b1 || done !== (c == FL - 1)) errs++;
          if (c % CPB == CPB / 2) s[c / CPB] = tx;
        end
        prev_end = cyc;
        last_bits = s;
        total++;
        if (errs != 0 || s[8:1] !== e) begin
          bad++;
          $display("FAIL frame got=%02h exp=%02h cyc_errs=%0d",
                   s[8:1], e, errs);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    valid = 1'b1;
    data = b;
    while (ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 3000) begin
      bad++;
      $display("FAIL accept_timeout got=busy exp=accept data=%02h", b);
    end else begin
      sb.push_back(b);
    end
    @(negedge clk);
    chk("ready_drop", 32'(ready), 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || mon_busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 3000) begin
      bad++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin : main
    int c0, t, lows, highs, run0, dpos;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx2", 32'(tx2), 1);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    send(8'hA5);
    valid = 1'b0;
    drain();
`ifdef XMIT_SER_PARITY_EN
    chk("t1_bits", 32'(last_bits[10:0]), 32'b10101001010);
`else
    chk("t1_bits", 32'(last_bits[9:0]), 32'b1101001010);
`endif
    chk("t1_busy_after", 32'(busy), 0);

    send(8'hA5);
    valid = 1'b0;
    drain();
`ifdef XMIT_SER_PARITY_EN
    chk("t2_par_a5", 32'(last_bits[9]), 0);
`endif
    send(8'h07);
    valid = 1'b0;
    drain();
`ifdef XMIT_SER_PARITY_EN
    chk("t2_par_07", 32'(last_bits[9]), 1);
`endif

    c0 = contig;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    valid = 1'b0;
    drain();
    chk("t3_contig", contig - c0, 2);

    send(8'h11);
    send(8'h3C);
    for (int i = 0; i < 20; i++) begin
      data = 8'hF0 ^ 8'(i);
      @(negedge clk);
    end
    valid = 1'b0;
    drain();

    mon_en = 1'b0;
    @(negedge clk);
    send(8'h55);
    send(8'h99);
    valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5_bit3", 32'(tx), 0);
    chk("t5_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx", 32'(tx), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(ready), 1);
    rst = 1'b0;
    lows = 0;
    highs = 0;
    for (int i = 0; i < 80; i++) begin
      if (tx !== 1'b1) lows++;
      if (done !== 1'b0) highs++;
      @(negedge clk);
    end
    chk("t5_line_quiet", lows, 0);
    chk("t5_no_done", highs, 0);
    sb.delete();
    mon_en = 1'b1;

    valid2 = 1'b1;
    data2 = 8'hFF;
    t = 0;
    while (ready2 !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    valid2 = 1'b0;
    t = 0;
    while (tx2 !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t4_start_seen", 32'(tx2), 0);
    lows = 0;
    highs = 0;
    run0 = 0;
    dpos = 0;
    for (int c = 1; c <= 400; c++) begin
      if (tx2 === 1'b0) begin
        lows++;
        if (highs == 0) run0++;
      end else begin
        highs++;
      end
      if (done2 === 1'b1) begin
        dpos = c;
        break;
      end
      @(negedge clk);
    end
    chk("t4_start_len", run0, 16);
    chk("t4_high_len", highs, 160);
    chk("t4_low_len", lows, 16 + 16 * P);
    chk("t4_done_pos", dpos, 176 + 16 * P);
    @(negedge clk);
    chk("t4_busy_after", 32'(busy2), 0);
    chk("t4_done_once", 32'(done2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
